// File: rtl/ld_str_pkg.sv
// Shared definitions for the load/store register file: default geometry,
// read-source encoding and the address range check.
package ld_str_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_AW    = 3;

  typedef enum logic [1:0] {
    SRC_ZERO   = 2'd0,
    SRC_BYPASS = 2'd1,
    SRC_STORE  = 2'd2
  } rd_src_e;

  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/ld_str_read_port.sv
// One read port: storage mux, range/zero gating, write bypass and an
// optional output register stage.
module ld_str_read_port
  import ld_str_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = DEF_AW,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0,
  parameter int RD_REG   = 0
) (
  input  logic                   i_clk,
  input  logic                   i_clr,
  input  logic [DEPTH*WIDTH-1:0] i_mem,
  input  logic                   i_wv,
  input  logic [AW-1:0]          i_wr_addr,
  input  logic [WIDTH-1:0]       i_wr_data,
  input  logic [AW-1:0]          i_addr,
  output logic [WIDTH-1:0]       o_rd_data
);

  logic [WIDTH-1:0] w_stored;
  logic [WIDTH-1:0] w_val;
  rd_src_e          w_src;

  // Compare-based mux so addresses past DEPTH never index outside the array.
  always_comb begin
    w_stored = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_addr == AW'(i)) w_stored = i_mem[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    w_src = SRC_STORE;
    if (!addr_in_range(32'(i_addr), 32'(DEPTH))) begin
      w_src = SRC_ZERO;
    end else if ((ZERO_REG != 0) && (i_addr == '0)) begin
      w_src = SRC_ZERO;
    end else if ((BYPASS != 0) && i_wv && (i_addr == i_wr_addr)) begin
      w_src = SRC_BYPASS;
    end
  end

  always_comb begin
    case (w_src)
      SRC_BYPASS: w_val = i_wr_data;
      SRC_STORE:  w_val = w_stored;
      default:    w_val = '0;
    endcase
  end

  if (RD_REG != 0) begin : g_rd_reg
    logic [WIDTH-1:0] r_rd_data_p1;

    // ---- stage p1: registered read data ----
    always_ff @(posedge i_clk) begin
      if (i_clr) r_rd_data_p1 <= '0;
      else       r_rd_data_p1 <= w_val;
    end

    assign o_rd_data = r_rd_data_p1;
  end else begin : g_rd_comb
    logic w_unused_ctl;
    assign w_unused_ctl = i_clk ^ i_clr;
    assign o_rd_data    = w_val;
  end

endmodule

// File: rtl/ld_str_reg_file.sv
// Bank of DEPTH load/store registers with one write port and two
// independent read ports (bypass, zero register, registered reads optional).
module ld_str_reg_file
  import ld_str_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = DEF_AW,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0,
  parameter int RD_REG   = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             wr_err
);

  if ((2 ** AW) < DEPTH) begin : g_param_check
    $error("ld_str_reg_file: 2**AW (%0d) is smaller than DEPTH (%0d)", 2 ** AW, DEPTH);
  end

  logic [DEPTH*WIDTH-1:0] r_mem;
  logic                   r_wr_err;
  logic                   w_in_range;
  logic                   w_zero_hit;
  logic                   w_wv;

  assign w_in_range = addr_in_range(32'(wr_addr), 32'(DEPTH));
  assign w_zero_hit = (ZERO_REG != 0) && (wr_addr == '0);
  // clr suppresses the write, which also suppresses bypass on both ports.
  assign w_wv       = load && !clr && w_in_range && !w_zero_hit;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_mem <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wv && (wr_addr == AW'(i))) r_mem[i*WIDTH +: WIDTH] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr)                     r_wr_err <= 1'b0;
    else if (load && !w_in_range) r_wr_err <= 1'b1;
  end

  assign wr_err = r_wr_err;

  ld_str_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW),
    .BYPASS(BYPASS), .ZERO_REG(ZERO_REG), .RD_REG(RD_REG)
  ) u_port_a (
    .i_clk    (clk),
    .i_clr    (clr),
    .i_mem    (r_mem),
    .i_wv     (w_wv),
    .i_wr_addr(wr_addr),
    .i_wr_data(wr_data),
    .i_addr   (rd_addr_a),
    .o_rd_data(rd_data_a)
  );

  ld_str_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW),
    .BYPASS(BYPASS), .ZERO_REG(ZERO_REG), .RD_REG(RD_REG)
  ) u_port_b (
    .i_clk    (clk),
    .i_clr    (clr),
    .i_mem    (r_mem),
    .i_wv     (w_wv),
    .i_wr_addr(wr_addr),
    .i_wr_data(wr_data),
    .i_addr   (rd_addr_b),
    .o_rd_data(rd_data_b)
  );

endmodule
